// File: rtl/ntt_ctrl.sv
// ntt_ctrl: address and enable sequencer for an in-place radix-2 Cooley-Tukey forward NTT.
// It issues one butterfly per cycle. The write-back trails each read by one cycle, which is the RAM/ROM read latency.
module ntt_ctrl #(
   parameter int N      = 256,
   parameter int LOG2N  = $clog2(N),
   parameter int ADDR_W = $clog2(N)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   rd_en,
   output logic [ADDR_W-1:0]      rd_addr_a,
   output logic [ADDR_W-1:0]      rd_addr_b,
   output logic [ADDR_W-1:0]      tw_addr,
   output logic                   wr_en,
   output logic [ADDR_W-1:0]      wr_addr_a,
   output logic [ADDR_W-1:0]      wr_addr_b,
   output logic [$clog2(LOG2N):0] stage
);

   localparam int                STAGE_W = $clog2(LOG2N) + 1;
   localparam logic [ADDR_W-1:0]  I_LAST  = ADDR_W'(N / 2 - 1);
   localparam logic [STAGE_W-1:0] S_LAST  = STAGE_W'(LOG2N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
      logic [ADDR_W-1:0] tw;
   } bfly_addr_t;

   state_t            state;
   logic [ADDR_W-1:0] idx;
   bfly_addr_t        rd_q;

   // Butterfly i of stage s works on two elements that are len = 2^(LOG2N-1-s) apart.
   // Block i>>L takes twiddle 2^s + block, so twiddle entry 0 is never addressed.
   function automatic bfly_addr_t bfly_addr(input logic [STAGE_W-1:0] s_v,
                                            input logic [ADDR_W-1:0]  i_v);
      bfly_addr_t        r;
      int                l_v;
      logic [ADDR_W-1:0] len_v;
      logic [ADDR_W-1:0] blk_v;
      l_v   = LOG2N - 1 - int'(s_v);
      len_v = ADDR_W'(1) << l_v;
      blk_v = i_v >> l_v;
      r.a   = ((blk_v << 1) << l_v) | (i_v & (len_v - ADDR_W'(1)));
      r.b   = r.a + len_v;
      r.tw  = (ADDR_W'(1) << s_v) + blk_v;
      return r;
   endfunction

   assign rd_addr_a = rd_q.a;
   assign rd_addr_b = rd_q.b;
   assign tw_addr   = rd_q.tw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         wr_en     <= 1'b0;
         rd_q      <= '0;
         wr_addr_a <= '0;
         wr_addr_b <= '0;
         stage     <= '0;
         idx       <= '0;
      end else begin
         // NOTE: non-blocking assignments make wr_* capture the rd_* values from before this edge.
         // That old read is exactly the butterfly whose data the RAM presents in the next cycle.
         wr_en <= rd_en;
         if (rd_en) begin
            wr_addr_a <= rd_q.a;
            wr_addr_b <= rd_q.b;
         end
         done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_RUN;
                  busy  <= 1'b1;
                  rd_en <= 1'b1;
                  stage <= '0;
                  idx   <= '0;
                  rd_q  <= bfly_addr('0, '0);
               end
            end
            S_RUN: begin
               if (idx == I_LAST) begin
                  state <= S_DRAIN;
                  rd_en <= 1'b0;
               end else begin
                  idx  <= idx + ADDR_W'(1);
                  rd_q <= bfly_addr(stage, idx + ADDR_W'(1));
               end
            end
            // The bubble lets the last write of this stage land before the next stage reads.
            S_DRAIN: begin
               if (stage == S_LAST) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  state <= S_RUN;
                  rd_en <= 1'b1;
                  stage <= stage + STAGE_W'(1);
                  idx   <= '0;
                  rd_q  <= bfly_addr(stage + STAGE_W'(1), '0);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               rd_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ntt_ctrl.md
Name: ntt_ctrl

Overview:
- Sequencer for one in-place radix-2 Cooley-Tukey forward NTT over an N-coefficient dual-port coefficient RAM, driving a single combinational ntt_butterfly.
- Generates RAM read/write addresses, enables and twiddle-ROM addresses, one butterfly issued per cycle.
- Datapath is external: RAM read data feeds the butterfly (a, b, twiddle) and the butterfly outputs (a_out, b_out) are written back.
- Sits between the top-level command interface (start/done) and the coefficient RAM / twiddle ROM.

Parameters:
- N, 256, transform length; power of two, N >= 4.
- LOG2N, $clog2(N), number of stages.
- ADDR_W, $clog2(N), coefficient and twiddle address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done inclusive
- done  out  1  one-cycle pulse when the transform is complete
- rd_en  out  1  RAM read enable, ports A and B
- rd_addr_a  out  ADDR_W  read address of butterfly input a
- rd_addr_b  out  ADDR_W  read address of butterfly input b
- tw_addr  out  ADDR_W  twiddle ROM address, aligned with rd_addr_* (ROM has the same 1-cycle latency as the RAM)
- wr_en  out  1  RAM write enable, ports A and B
- wr_addr_a  out  ADDR_W  write address for a_out
- wr_addr_b  out  ADDR_W  write address for b_out
- stage  out  $clog2(LOG2N)+1  current stage index, for debug

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, rd_en and wr_en are 0. All address outputs and stage are 0. Counters are cleared.
- Reset mid-transform: abort immediately. No further writes. RAM contents are undefined.
- States:
  - IDLE: start=1 -> RUN with s=0, i=0.
  - RUN: issue one butterfly per cycle, i=0..N/2-1. After i=N/2-1 -> DRAIN.
  - DRAIN: 1 cycle. No read; write-back of the last butterfly of the stage. If s<LOG2N-1: s++, i=0, -> RUN. Otherwise -> DONE.
  - DONE: done=1 for 1 cycle -> IDLE.
- Address generation in RUN, with L=LOG2N-1-s (len=2^L):
  - rd_addr_a = ((i>>L)<<(L+1)) | (i & (len-1))
  - rd_addr_b = rd_addr_a + len
  - tw_addr = 2^s + (i>>L)
  - rd_en=1. tw_addr never equals 0; ROM entry 0 is unused.
- Write pipeline:
  - RAM and ROM have 1-cycle read latency.
  - wr_addr_a/b are rd_addr_a/b registered by 1 cycle.
  - wr_en = rd_en delayed 1 cycle, so the write lands in the cycle the read data is valid (combinational butterfly).
  - Writes occur in RUN cycles i>=1 and in DRAIN.
- Hazard rule: the DRAIN bubble guarantees no stage-(s+1) read targets an address written in the same cycle. The RAM read-during-write behaviour is irrelevant.
- When rd_en=0 the address outputs hold their last value. When wr_en=0 the write addresses hold their last value.
- start while busy: ignored. Start in the same cycle as done: ignored (state is DONE, not IDLE).
- Latency: start accepted at cycle 0 -> first read at cycle 1 -> done high at cycle LOG2N*(N/2+1)+1. Total RAM writes = LOG2N*N/2.
- busy=1 in RUN, DRAIN and DONE. busy=0 in IDLE.

Test Plan:
- N=8, single start -> (rd_addr_a, rd_addr_b, tw_addr) sequence:
  - stage 0: (0,4,1) (1,5,1) (2,6,1) (3,7,1)
  - stage 1: (0,2,2) (1,3,2) (4,6,3) (5,7,3)
  - stage 2: (0,1,4) (2,3,5) (4,5,6) (6,7,7)
  - done pulses at cycle 16; busy is high for cycles 1-16.
- N=8, write channel -> wr_addr_a/b equals the previous cycle's rd_addr_a/b whenever wr_en=1. No rd_en in DRAIN cycles (5, 10, 15). 12 writes total.
- N=256 with a RAM model, ntt_butterfly and Q=8380417 zetas ROM; coefficient input x[0]=1, rest 0 -> all outputs equal 1. Random input matches the golden software NTT; done at cycle 1033.
- start held high continuously -> back-to-back transforms, each 1 IDLE cycle apart. Start pulses during busy do not shift addresses or timing.
- rst_n asserted during stage 1 of N=8 -> outputs go to 0 asynchronously. After release, a new start reproduces the full sequence from (0,4,1).
- start coincident with the done cycle -> ignored. busy=0 next cycle. A start one cycle later is accepted.
